ser_align_ctrl: RTL and testbench

Receive-side alignment controller for the serial link: on `clk_32f` it hunts the serial stream for the comma byte `COMMA`, qualifies byte alignment over `LOCK_CNT` consecutive aligned commas, then emits aligned parallel bytes. It drops lock after `LOSS_GAP` consecutive non-comma bytes or on an external `realign` request. It is the sequencing front-end for the serial-to-parallel path: it drives `active`/`valid_out` for the downstream byte consumer, and no separate `clk_4f` is required.

---
 rtl/ser_align_ctrl.sv | 179 +++++++++++++++++
 tb/tb_ser_align_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ser_align_ctrl.sv
// ---------------------------------------------------------------------------
// ser_align_ctrl
//
// Receive-side byte alignment controller for the serial link.
// The controller works on the bit clock. It hunts the serial stream for the
// comma symbol and then qualifies the alignment over several consecutive
// aligned commas. Once locked, it delivers each aligned non-comma byte to the
// downstream consumer. Lock is dropped after too many consecutive non-comma
// bytes, or when the link layer asks for a re-hunt.
//
// Parameters:
//   COMMA     alignment/idle symbol (nonzero, MSB set)
//   LOCK_CNT  aligned commas needed to declare lock (1..15)
//   LOSS_GAP  consecutive non-comma bytes in lock that drop it (1..255)
//
// Ports:
//   clk_32f    in   bit clock, all logic on its rising edge
//   reset      in   synchronous, active-low reset
//   data_in    in   serial data, MSB first, one bit per edge
//   realign    in   synchronous forced re-hunt request
//   data_out   out  [7:0] last aligned non-comma byte, held between updates
//   valid_out  out  one-cycle strobe when data_out presents a new byte
//   active     out  high while locked
//   sync_err   out  one-cycle pulse when lock is lost through the gap limit
// ---------------------------------------------------------------------------
module ser_align_ctrl #(
  parameter logic [7:0]  COMMA    = 8'hBC,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_GAP = 64
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  input  logic       realign,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic       sync_err
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Terminal counter values, pre-sized to the counter widths.
  localparam logic [3:0] LOCK_LAST = 4'(LOCK_CNT - 32'd1);
  localparam logic [7:0] GAP_LAST  = 8'(LOSS_GAP - 32'd1);
  localparam logic       LOCK_ONE  = (LOCK_CNT == 32'd1);

  state_t      state_r,     state_s;
  logic [7:0]  sr_r;
  logic [2:0]  bit_cnt_r,   bit_cnt_s;
  logic [3:0]  comma_cnt_r, comma_cnt_s;
  logic [7:0]  gap_r,       gap_s;
  logic [7:0]  data_out_r,  data_out_s;
  logic        valid_out_r, valid_out_s;
  logic        active_r,    active_s;
  logic        sync_err_r,  sync_err_s;
  logic        is_comma_s;
  logic        boundary_s;

  // Next-state and next-output logic for the alignment FSM.
  always_comb begin
    is_comma_s  = (sr_r == COMMA);
    // Outside HUNT, bit_cnt == 0 marks the cycle in which sr holds a whole byte.
    boundary_s  = (bit_cnt_r == 3'd0);
    state_s     = state_r;
    bit_cnt_s   = bit_cnt_r + 3'd1;
    comma_cnt_s = comma_cnt_r;
    gap_s       = gap_r;
    data_out_s  = data_out_r;
    valid_out_s = 1'b0;
    active_s    = active_r;
    sync_err_s  = 1'b0;

    if (realign) begin
      // A re-hunt request overrides any boundary decision in this cycle.
      state_s     = ST_HUNT;
      comma_cnt_s = 4'd0;
      gap_s       = 8'd0;
      active_s    = 1'b0;
    end else begin
      case (state_r)
        ST_HUNT: begin
          if (is_comma_s) begin
            // The match cycle counts as bit 0, so the next boundary is 8 cycles later.
            bit_cnt_s   = 3'd1;
            comma_cnt_s = 4'd1;
            if (LOCK_ONE) begin
              state_s  = ST_LOCKED;
              active_s = 1'b1;
              gap_s    = 8'd0;
            end else begin
              state_s = ST_VERIFY;
            end
          end else begin
            state_s = ST_HUNT;
          end
        end

        ST_VERIFY: begin
          if (boundary_s) begin
            if (is_comma_s && (comma_cnt_r == LOCK_LAST)) begin
              state_s  = ST_LOCKED;
              active_s = 1'b1;
              gap_s    = 8'd0;
            end else if (is_comma_s) begin
              comma_cnt_s = comma_cnt_r + 4'd1;
            end else begin
              state_s     = ST_HUNT;
              comma_cnt_s = 4'd0;
            end
          end else begin
            state_s = ST_VERIFY;
          end
        end

        ST_LOCKED: begin
          if (boundary_s) begin
            if (is_comma_s) begin
              gap_s = 8'd0;
            end else if (gap_r == GAP_LAST) begin
              // The byte that exhausts the gap budget is dropped, not delivered.
              state_s    = ST_HUNT;
              active_s   = 1'b0;
              sync_err_s = 1'b1;
            end else begin
              data_out_s  = sr_r;
              valid_out_s = 1'b1;
              gap_s       = gap_r + 8'd1;
            end
          end else begin
            state_s = ST_LOCKED;
          end
        end

        default: begin
          state_s     = ST_HUNT;
          comma_cnt_s = 4'd0;
          gap_s       = 8'd0;
          active_s    = 1'b0;
        end
      endcase
    end
  end

  // State, shift register, counters and registered outputs.
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state_r     <= ST_HUNT;
      sr_r        <= 8'h00;
      bit_cnt_r   <= 3'd0;
      comma_cnt_r <= 4'd0;
      gap_r       <= 8'd0;
      data_out_r  <= 8'h00;
      valid_out_r <= 1'b0;
      active_r    <= 1'b0;
      sync_err_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      sr_r        <= {sr_r[6:0], data_in};
      bit_cnt_r   <= bit_cnt_s;
      comma_cnt_r <= comma_cnt_s;
      gap_r       <= gap_s;
      data_out_r  <= data_out_s;
      valid_out_r <= valid_out_s;
      active_r    <= active_s;
      sync_err_r  <= sync_err_s;
    end
  end

  assign data_out  = data_out_r;
  assign valid_out = valid_out_r;
  assign active    = active_r;
  assign sync_err  = sync_err_r;

endmodule

// File: tb/tb_ser_align_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ser_align_ctrl
//
// Directed bench for ser_align_ctrl (COMMA=BC, LOCK_CNT=4, LOSS_GAP=4).
// Bits are driven on the falling edge, so each bit is sampled by the next
// rising edge. Expected data bytes are queued together with the rising-edge
// count at which their strobe must be visible. A falling-edge monitor pops
// the queue on every strobe and compares both the data and the timing.
// ---------------------------------------------------------------------------
module tb_ser_align_ctrl;

  logic       clk_32f;
  logic       reset;
  logic       data_in;
  logic       realign;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       sync_err;

  int          checks    = 0;
  int          errors    = 0;
  int unsigned edge_cnt  = 0;
  int unsigned sync_seen = 0;
  int unsigned sync_base = 0;

  typedef struct {
    logic [7:0]  data;
    int unsigned at_edge;
  } exp_t;

  exp_t exp_q[$];

  ser_align_ctrl #(
    .COMMA    (8'hBC),
    .LOCK_CNT (4),
    .LOSS_GAP (4)
  ) dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .realign   (realign),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active),
    .sync_err  (sync_err)
  );

  // Bit clock.
  initial begin
    clk_32f = 1'b0;
    forever #5 clk_32f = ~clk_32f;
  end

  // Rising-edge counter used to time strobes.
  always @(posedge clk_32f) begin
    edge_cnt <= edge_cnt + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe scoreboard and sync_err pulse counter.
  always @(negedge clk_32f) begin
    exp_t got;
    if (valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("stray_strobe", {31'd0, valid_out}, 32'd0);
      end else begin
        got = exp_q.pop_front();
        check("strobe_data", {24'd0, data_out}, {24'd0, got.data});
        check("strobe_time", edge_cnt, got.at_edge);
      end
    end
    if (sync_err === 1'b1) begin
      sync_seen <= sync_seen + 32'd1;
    end
  end

  // Watchdog so that the run always terminates.
  initial begin
    #1000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic send_bit(input logic b);
    data_in = b;
    @(negedge clk_32f);
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      send_bit(v[i]);
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    send_bits(v, 8);
  endtask

  task automatic push_exp(input logic [7:0] v);
    exp_t e;
    e.data    = v;
    e.at_edge = edge_cnt + 32'd1;
    exp_q.push_back(e);
  endtask

  task automatic send_data(input logic [7:0] v);
    send_byte(v);
    push_exp(v);
  endtask

  // Four commas, then the data byte nxt. Active must rise exactly one edge
  // after the last bit of the fourth comma.
  task automatic lock_up(input string tag, input logic [7:0] nxt);
    repeat (4) send_byte(8'hBC);
    check({tag, "_active_pre"}, {31'd0, active}, 32'd0);
    send_bit(nxt[7]);
    check({tag, "_active_post"}, {31'd0, active}, 32'd1);
    send_bits(nxt, 7);
    push_exp(nxt);
  endtask

  task automatic apply_reset(input int cycles, input bit chk);
    reset = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      data_in = 1'($urandom_range(1, 0));
      @(negedge clk_32f);
      if (chk) begin
        check("reset_outputs", {21'd0, data_out, valid_out, active, sync_err}, 32'd0);
      end
    end
    reset   = 1'b1;
    data_in = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    data_in = 1'b0;
    realign = 1'b0;

    // Reset held with random data, then released with idle zeros.
    apply_reset(20, 1'b1);
    repeat (16) send_bit(1'b0);
    check("release_active", {31'd0, active}, 32'd0);
    check("release_data", {24'd0, data_out}, 32'd0);

    // Basic lock at an arbitrary bit offset, then two data bytes.
    send_bits(8'($urandom_range(7, 0)), 3);
    lock_up("basic", 8'h5A);
    send_data(8'h3C);
    send_byte(8'hBC);
    check("basic_drain", exp_q.size(), 32'd0);
    check("basic_active", {31'd0, active}, 32'd1);
    apply_reset(4, 1'b0);

    // A failed verify returns to hunt; four fresh commas then lock.
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h00);
    check("fail_active", {31'd0, active}, 32'd0);
    lock_up("relock", 8'h77);
    send_byte(8'hBC);
    check("relock_drain", exp_q.size(), 32'd0);
    apply_reset(4, 1'b0);

    // Gap loss: the fourth consecutive data byte drops lock and is discarded.
    sync_base = sync_seen;
    lock_up("gap", 8'h11);
    send_data(8'h22);
    send_data(8'h33);
    send_byte(8'h44);
    check("gap_pre_sync", {31'd0, sync_err}, 32'd0);
    check("gap_pre_active", {31'd0, active}, 32'd1);
    send_bit(1'b0);
    check("gap_sync_err", {31'd0, sync_err}, 32'd1);
    check("gap_active_fall", {31'd0, active}, 32'd0);
    check("gap_no_strobe", {31'd0, valid_out}, 32'd0);
    check("gap_data_hold", {24'd0, data_out}, 32'h33);
    send_bit(1'b0);
    check("gap_sync_pulse", {31'd0, sync_err}, 32'd0);
    repeat (16) send_bit(1'b0);
    check("gap_drain", exp_q.size(), 32'd0);
    check("gap_sync_count", sync_seen - sync_base, 32'd1);
    check("gap_active_hunt", {31'd0, active}, 32'd0);
    apply_reset(4, 1'b0);

    // A comma inside the data stream restarts the gap count.
    sync_base = sync_seen;
    lock_up("gapr", 8'h11);
    send_data(8'h22);
    send_data(8'h33);
    send_byte(8'hBC);
    send_data(8'h44);
    send_data(8'h55);
    repeat (4) send_bit(1'b0);
    check("gapr_drain", exp_q.size(), 32'd0);
    check("gapr_no_sync", sync_seen - sync_base, 32'd0);
    check("gapr_active", {31'd0, active}, 32'd1);
    apply_reset(4, 1'b0);

    // Realign mid-byte, then relock at a new bit offset.
    sync_base = sync_seen;
    lock_up("ra", 8'hAA);
    send_bits(8'h00, 3);
    realign = 1'b1;
    send_bit(1'b0);
    realign = 1'b0;
    check("ra_active", {31'd0, active}, 32'd0);
    check("ra_sync", {31'd0, sync_err}, 32'd0);
    check("ra_data_hold", {24'd0, data_out}, 32'hAA);
    send_bits(8'h00, 7);
    lock_up("ra_relock", 8'h5A);
    send_byte(8'hBC);
    check("ra_drain", exp_q.size(), 32'd0);
    check("ra_no_sync", sync_seen - sync_base, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
